// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store pipeline stage: FSM encoding, default widths.
package lsu_stage_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned RIDX_W = 3;
    localparam int unsigned TMO_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    typedef logic [RIDX_W-1:0] ridx_t;

endpackage

// File: rtl/lsu_stage_if.sv
// Data-memory request/response bus between the LSU stage (master) and memory (slave).
interface lsu_stage_if #(
    parameter int unsigned DW = lsu_stage_pkg::DW_DEF
) ();

    logic          dmem_req_o;
    logic          dmem_we_o;
    logic [DW-1:0] dmem_addr_o;
    logic [DW-1:0] dmem_wdata_o;
    logic          dmem_gnt_i;
    logic          dmem_rvalid_i;
    logic [DW-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

endinterface

// File: rtl/lsu_timeout_ctr.sv
// Load-data timeout counter: expire_c flags the enabled cycle whose increment would reach limit.
module lsu_timeout_ctr
    import lsu_stage_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic             expire_c
);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end
    end

    assign expire_c = enable && (cnt_q == (limit - TMO_W'(1)));

endmodule

// File: rtl/lsu_stage.sv
// Load/store pipeline stage: issues one data-memory op at a time and produces the writeback slot.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ex_valid_i,
    input  logic [DW-1:0] ex_pc_i,
    input  logic          ex_load_i,
    input  logic          ex_store_i,
    input  ridx_t         ex_rd_idx_i,
    input  logic [DW-1:0] ex_addr_i,
    input  logic [DW-1:0] ex_wdata_i,
    input  logic [DW-1:0] ex_result_i,
    lsu_stage_if.master   dmem,
    output logic          wb_valid_o,
    output logic [DW-1:0] wb_pc_o,
    output ridx_t         wb_rd_idx_o,
    output logic [DW-1:0] wb_val_o,
    output ridx_t         mem_rd_idx_o,
    output logic [DW-1:0] mem_val_o,
    output logic          lsu_stall_o,
    output logic          lsu_err_o
);

    lsu_state_e    state_q, state_d;
    logic          req_q, we_q, stall_q;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          store_q, store_d;
    ridx_t         rd_q, rd_d;
    logic [DW-1:0] pc_q, pc_d;
    logic          wb_valid_q, wb_valid_d;
    logic [DW-1:0] wb_pc_q, wb_pc_d;
    ridx_t         wb_rd_q, wb_rd_d;
    logic [DW-1:0] wb_val_q, wb_val_d;
    logic          err_q, err_d;
    logic          tmo_expire_c;

    lsu_timeout_ctr u_tmo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear    (state_q != ST_WAIT),
        .enable   ((state_q == ST_WAIT) && !dmem.dmem_rvalid_i),
        .limit    (TMO_W'(TIMEOUT_CYC)),
        .expire_c (tmo_expire_c)
    );

    // State and output registers; every output is reset to zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            stall_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            store_q    <= 1'b0;
            rd_q       <= '0;
            pc_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_pc_q    <= '0;
            wb_rd_q    <= '0;
            wb_val_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= (state_d == ST_REQ);
            we_q       <= (state_d == ST_REQ) && store_d;
            stall_q    <= (state_d != ST_IDLE);
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            store_q    <= store_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            wb_valid_q <= wb_valid_d;
            wb_pc_q    <= wb_pc_d;
            wb_rd_q    <= wb_rd_d;
            wb_val_q   <= wb_val_d;
            err_q      <= err_d;
        end
    end

    // Next state and next output values; idle cycles drive index 0 so forwarding only hits r0.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        store_d    = store_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        wb_valid_d = 1'b0;
        wb_pc_d    = wb_pc_q;
        wb_rd_d    = '0;
        wb_val_d   = wb_val_q;
        err_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ex_valid_i) begin
                    if (ex_load_i || ex_store_i) begin
                        addr_d  = ex_addr_i;
                        wdata_d = ex_wdata_i;
                        store_d = ex_store_i;
                        rd_d    = ex_rd_idx_i;
                        pc_d    = ex_pc_i;
                        state_d = ST_REQ;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_pc_d    = ex_pc_i;
                        wb_rd_d    = ex_rd_idx_i;
                        wb_val_d   = ex_result_i;
                    end
                end
            end
            ST_REQ: begin
                if (dmem.dmem_gnt_i) begin
                    if (store_q) begin
                        wb_valid_d = 1'b1;
                        wb_pc_d    = pc_q;
                        wb_val_d   = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem.dmem_rvalid_i) begin
                    wb_valid_d = 1'b1;
                    wb_pc_d    = pc_q;
                    wb_rd_d    = rd_q;
                    wb_val_d   = dmem.dmem_rdata_i;
                    state_d    = ST_IDLE;
                end else if (tmo_expire_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_wdata_o = wdata_q;

    assign wb_valid_o   = wb_valid_q;
    assign wb_pc_o      = wb_pc_q;
    assign wb_rd_idx_o  = wb_rd_q;
    assign wb_val_o     = wb_val_q;
    assign mem_rd_idx_o = wb_rd_q;
    assign mem_val_o    = wb_val_q;
    assign lsu_stall_o  = stall_q;
    assign lsu_err_o    = err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage: ALU passthrough, load, store, timeout, reset, back-to-back.
module tb_lsu_stage;
    import lsu_stage_pkg::*;

    localparam int unsigned DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ex_valid_i, ex_load_i, ex_store_i;
    logic [DW-1:0] ex_pc_i, ex_addr_i, ex_wdata_i, ex_result_i;
    ridx_t         ex_rd_idx_i;
    logic          wb_valid_o, lsu_stall_o, lsu_err_o;
    logic [DW-1:0] wb_pc_o, wb_val_o, mem_val_o;
    ridx_t         wb_rd_idx_o, mem_rd_idx_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    lsu_stage_if #(.DW(DW)) dmem_if ();

    lsu_stage #(.DW(DW), .TIMEOUT_CYC(15)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ex_valid_i   (ex_valid_i),
        .ex_pc_i      (ex_pc_i),
        .ex_load_i    (ex_load_i),
        .ex_store_i   (ex_store_i),
        .ex_rd_idx_i  (ex_rd_idx_i),
        .ex_addr_i    (ex_addr_i),
        .ex_wdata_i   (ex_wdata_i),
        .ex_result_i  (ex_result_i),
        .dmem         (dmem_if),
        .wb_valid_o   (wb_valid_o),
        .wb_pc_o      (wb_pc_o),
        .wb_rd_idx_o  (wb_rd_idx_o),
        .wb_val_o     (wb_val_o),
        .mem_rd_idx_o (mem_rd_idx_o),
        .mem_val_o    (mem_val_o),
        .lsu_stall_o  (lsu_stall_o),
        .lsu_err_o    (lsu_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic ld, input logic st, input ridx_t rd,
                           input logic [DW-1:0] pc, input logic [DW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] res);
        ex_valid_i  = 1'b1;
        ex_load_i   = ld;
        ex_store_i  = st;
        ex_rd_idx_i = rd;
        ex_pc_i     = pc;
        ex_addr_i   = addr;
        ex_wdata_i  = wdata;
        ex_result_i = res;
    endtask

    initial begin
        rst_i = 1'b0;
        ex_valid_i = 1'b0; ex_load_i = 1'b0; ex_store_i = 1'b0;
        ex_rd_idx_i = '0; ex_pc_i = '0; ex_addr_i = '0; ex_wdata_i = '0; ex_result_i = '0;
        dmem_if.dmem_gnt_i = 1'b0; dmem_if.dmem_rvalid_i = 1'b0; dmem_if.dmem_rdata_i = '0;
        tick(); tick();
        chk("rst_wb_valid", 32'(wb_valid_o), 32'h0);
        chk("rst_req", 32'(dmem_if.dmem_req_o), 32'h0);
        chk("rst_stall", 32'(lsu_stall_o), 32'h0);
        chk("rst_wb_val", 32'(wb_val_o), 32'h0);
        rst_i = 1'b1;

        // Non-memory op writes back the ALU result the next cycle without stalling
        present(1'b0, 1'b0, 3'd3, 16'h0100, 16'h0, 16'h0, 16'h1234);
        tick();
        chk("alu_wb_valid", 32'(wb_valid_o), 32'h1);
        chk("alu_wb_val", 32'(wb_val_o), 32'h1234);
        chk("alu_wb_rd", 32'(wb_rd_idx_o), 32'h3);
        chk("alu_wb_pc", 32'(wb_pc_o), 32'h0100);
        chk("alu_fwd_rd", 32'(mem_rd_idx_o), 32'h3);
        chk("alu_fwd_val", 32'(mem_val_o), 32'h1234);
        chk("alu_stall", 32'(lsu_stall_o), 32'h0);
        ex_valid_i = 1'b0;
        tick();
        chk("idle_wb_valid", 32'(wb_valid_o), 32'h0);
        chk("idle_wb_rd", 32'(wb_rd_idx_o), 32'h0);
        chk("idle_wb_val_hold", 32'(wb_val_o), 32'h1234);

        // Load, grant after two REQ cycles, an ALU op presented during stall must be ignored
        present(1'b1, 1'b0, 3'd5, 16'h0104, 16'h0040, 16'h0, 16'h0);
        tick();
        chk("ld_req1", 32'(dmem_if.dmem_req_o), 32'h1);
        chk("ld_addr1", 32'(dmem_if.dmem_addr_o), 32'h0040);
        chk("ld_we", 32'(dmem_if.dmem_we_o), 32'h0);
        chk("ld_stall_req1", 32'(lsu_stall_o), 32'h1);
        present(1'b0, 1'b0, 3'd7, 16'h0200, 16'h0, 16'h0, 16'hDEAD);
        tick();
        chk("ld_req2", 32'(dmem_if.dmem_req_o), 32'h1);
        chk("ld_addr2", 32'(dmem_if.dmem_addr_o), 32'h0040);
        chk("ld_ignored_ex", 32'(wb_valid_o), 32'h0);
        ex_valid_i = 1'b0;
        dmem_if.dmem_gnt_i = 1'b1;
        dmem_if.dmem_rvalid_i = 1'b1;
        dmem_if.dmem_rdata_i = 16'h1111;
        tick();
        chk("ld_wait_req", 32'(dmem_if.dmem_req_o), 32'h0);
        chk("ld_gnt_rvalid_ignored", 32'(wb_valid_o), 32'h0);
        chk("ld_stall_wait", 32'(lsu_stall_o), 32'h1);
        dmem_if.dmem_gnt_i = 1'b0;
        dmem_if.dmem_rvalid_i = 1'b0;
        tick(); tick();
        chk("ld_stall_wait3", 32'(lsu_stall_o), 32'h1);
        chk("ld_no_wb_yet", 32'(wb_valid_o), 32'h0);
        dmem_if.dmem_rvalid_i = 1'b1;
        dmem_if.dmem_rdata_i = 16'hBEEF;
        tick();
        dmem_if.dmem_rvalid_i = 1'b0;
        chk("ld_wb_valid", 32'(wb_valid_o), 32'h1);
        chk("ld_wb_val", 32'(wb_val_o), 32'hBEEF);
        chk("ld_wb_rd", 32'(wb_rd_idx_o), 32'h5);
        chk("ld_wb_pc", 32'(wb_pc_o), 32'h0104);
        chk("ld_stall_done", 32'(lsu_stall_o), 32'h0);

        // Store with immediate grant
        present(1'b0, 1'b1, 3'd6, 16'h0108, 16'h0010, 16'hA5A5, 16'h0);
        tick();
        chk("st_req", 32'(dmem_if.dmem_req_o), 32'h1);
        chk("st_we", 32'(dmem_if.dmem_we_o), 32'h1);
        chk("st_addr", 32'(dmem_if.dmem_addr_o), 32'h0010);
        chk("st_wdata", 32'(dmem_if.dmem_wdata_o), 32'hA5A5);
        chk("st_no_wb_in_req", 32'(wb_valid_o), 32'h0);
        ex_valid_i = 1'b0;
        dmem_if.dmem_gnt_i = 1'b1;
        tick();
        dmem_if.dmem_gnt_i = 1'b0;
        chk("st_wb_valid", 32'(wb_valid_o), 32'h1);
        chk("st_wb_rd", 32'(wb_rd_idx_o), 32'h0);
        chk("st_wb_val", 32'(wb_val_o), 32'h0);
        chk("st_req_drop", 32'(dmem_if.dmem_req_o), 32'h0);
        chk("st_we_drop", 32'(dmem_if.dmem_we_o), 32'h0);
        chk("st_stall", 32'(lsu_stall_o), 32'h0);
        tick();
        chk("st_wb_pulse", 32'(wb_valid_o), 32'h0);

        // Load with rvalid withheld: error after the 15th WAIT cycle
        present(1'b1, 1'b0, 3'd2, 16'h010C, 16'h0020, 16'h0, 16'h0);
        tick();
        ex_valid_i = 1'b0;
        dmem_if.dmem_gnt_i = 1'b1;
        tick();
        dmem_if.dmem_gnt_i = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("tmo_no_err_early", 32'(lsu_err_o), 32'h0);
        end
        chk("tmo_stall_early", 32'(lsu_stall_o), 32'h1);
        tick();
        chk("tmo_err", 32'(lsu_err_o), 32'h1);
        chk("tmo_no_wb", 32'(wb_valid_o), 32'h0);
        chk("tmo_idle", 32'(lsu_stall_o), 32'h0);
        tick();
        chk("tmo_err_pulse", 32'(lsu_err_o), 32'h0);

        // rvalid on the expiring cycle wins over the timeout
        present(1'b1, 1'b0, 3'd1, 16'h0114, 16'h0024, 16'h0, 16'h0);
        tick();
        ex_valid_i = 1'b0;
        dmem_if.dmem_gnt_i = 1'b1;
        tick();
        dmem_if.dmem_gnt_i = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        dmem_if.dmem_rvalid_i = 1'b1;
        dmem_if.dmem_rdata_i = 16'h7777;
        tick();
        dmem_if.dmem_rvalid_i = 1'b0;
        chk("race_err", 32'(lsu_err_o), 32'h0);
        chk("race_wb_valid", 32'(wb_valid_o), 32'h1);
        chk("race_wb_val", 32'(wb_val_o), 32'h7777);

        // Reset during WAIT, then stale grant/rvalid
        present(1'b1, 1'b0, 3'd4, 16'h0110, 16'h0030, 16'h0, 16'h0);
        tick();
        ex_valid_i = 1'b0;
        dmem_if.dmem_gnt_i = 1'b1;
        tick();
        dmem_if.dmem_gnt_i = 1'b0;
        rst_i = 1'b0;
        tick();
        chk("rw_wb_valid", 32'(wb_valid_o), 32'h0);
        chk("rw_wb_val", 32'(wb_val_o), 32'h0);
        chk("rw_wb_pc", 32'(wb_pc_o), 32'h0);
        chk("rw_req", 32'(dmem_if.dmem_req_o), 32'h0);
        chk("rw_addr", 32'(dmem_if.dmem_addr_o), 32'h0);
        chk("rw_stall", 32'(lsu_stall_o), 32'h0);
        chk("rw_err", 32'(lsu_err_o), 32'h0);
        rst_i = 1'b1;
        dmem_if.dmem_gnt_i = 1'b1;
        dmem_if.dmem_rvalid_i = 1'b1;
        dmem_if.dmem_rdata_i = 16'h5555;
        tick(); tick();
        chk("stale_wb_valid", 32'(wb_valid_o), 32'h0);
        chk("stale_wb_val", 32'(wb_val_o), 32'h0);
        chk("stale_stall", 32'(lsu_stall_o), 32'h0);
        chk("stale_req", 32'(dmem_if.dmem_req_o), 32'h0);
        dmem_if.dmem_gnt_i = 1'b0;
        dmem_if.dmem_rvalid_i = 1'b0;

        // Back-to-back loads; second uses rd=0
        present(1'b1, 1'b0, 3'd1, 16'h0120, 16'h0050, 16'h0, 16'h0);
        tick();
        ex_valid_i = 1'b0;
        dmem_if.dmem_gnt_i = 1'b1;
        tick();
        dmem_if.dmem_gnt_i = 1'b0;
        dmem_if.dmem_rvalid_i = 1'b1;
        dmem_if.dmem_rdata_i = 16'h0A0A;
        tick();
        dmem_if.dmem_rvalid_i = 1'b0;
        chk("b2b_a_wb_val", 32'(wb_val_o), 32'h0A0A);
        chk("b2b_a_wb_rd", 32'(wb_rd_idx_o), 32'h1);
        present(1'b1, 1'b0, 3'd0, 16'h0124, 16'h0060, 16'h0, 16'h0);
        tick();
        ex_valid_i = 1'b0;
        chk("b2b_b_req", 32'(dmem_if.dmem_req_o), 32'h1);
        chk("b2b_b_addr", 32'(dmem_if.dmem_addr_o), 32'h0060);
        dmem_if.dmem_gnt_i = 1'b1;
        tick();
        dmem_if.dmem_gnt_i = 1'b0;
        dmem_if.dmem_rvalid_i = 1'b1;
        dmem_if.dmem_rdata_i = 16'h1357;
        tick();
        dmem_if.dmem_rvalid_i = 1'b0;
        chk("b2b_b_wb_valid", 32'(wb_valid_o), 32'h1);
        chk("b2b_b_wb_rd0", 32'(wb_rd_idx_o), 32'h0);
        chk("b2b_b_wb_val", 32'(wb_val_o), 32'h1357);
        chk("b2b_b_wb_pc", 32'(wb_pc_o), 32'h0124);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter DW, default 16: datapath and address width in bits.
REQ-002 Parameter TIMEOUT_CYC, default 15: maximum cycles the block waits for load data; range 1..15.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-low.
REQ-005 ex_valid_i  in  1  execute slot valid.
REQ-006 ex_pc_i  in  DW  pc of the execute slot.
REQ-007 ex_load_i / ex_store_i  in  1 each  slot is a load word / store word; never both.
REQ-008 ex_rd_idx_i  in  3  destination register index.
REQ-009 ex_addr_i  in  DW  word address of the memory op.
REQ-010 ex_wdata_i  in  DW  store data.
REQ-011 ex_result_i  in  DW  ALU result for non-memory ops.
REQ-012 dmem_req_o, dmem_we_o  out  1 each  request and write-enable.
REQ-013 dmem_addr_o, dmem_wdata_o  out  DW each  request address and write data.
REQ-014 dmem_gnt_i, dmem_rvalid_i  in  1 each  request accepted; read data valid.
REQ-015 dmem_rdata_i  in  DW  read data.
REQ-016 wb_valid_o  out  1  writeback slot valid.
REQ-017 wb_pc_o  out  DW  pc of the writeback slot.
REQ-018 wb_rd_idx_o  out  3  writeback index.
REQ-019 wb_val_o  out  DW  writeback value.
REQ-020 mem_rd_idx_o / mem_val_o  out  3 / DW  forwarding tap; equal to the wb_* pair.
REQ-021 lsu_stall_o  out  1  hold execute output.
REQ-022 lsu_err_o  out  1  one-cycle pulse on load timeout.

Function
REQ-023 FSM states: IDLE, REQ, WAIT. Bus is held in REQ until grant; WAIT awaits load data.
REQ-024 Accept: in IDLE with ex_valid_i=1 on edge T.
  - Non-memory op: wb_* registered at T+1 with ex_result_i, ex_rd_idx_i, ex_pc_i; FSM remains in IDLE.
  - Memory op: latch addr, wdata, rd and pc; enter REQ at T+1.
REQ-025 lsu_stall_o SHALL equal (state != IDLE). ex_* inputs are ignored while stall is high.
REQ-026 REQ behaviour:
  - dmem_req_o=1 and addr/wdata/we stable until the cycle dmem_gnt_i=1.
  - Store with grant: wb_valid_o=1 next cycle with wb_rd_idx_o=0 and wb_val_o=0; return to IDLE.
  - Load with grant: enter WAIT.
REQ-027 dmem_rvalid_i SHALL be ignored outside WAIT, including in the grant cycle.
REQ-028 WAIT with dmem_rvalid_i=1: next cycle wb_valid_o=1, wb_val_o=dmem_rdata_i, wb_rd_idx_o=latched rd; return to IDLE.
REQ-029 WAIT timeout:
  - A 4-bit counter clears on WAIT entry and increments each WAIT cycle without rvalid.
  - When it reaches TIMEOUT_CYC: pulse lsu_err_o, no writeback, return to IDLE.
  - rvalid in that same cycle wins over the timeout.
REQ-030 Cycles without a completed op: wb_valid_o=0 and wb_rd_idx_o=0 so forwarding matches only r0; wb_val_o holds.
REQ-031 A load with rd=0 completes normally and writes back index 0, which is write-protected downstream.
REQ-032 Load latency is at least 3 cycles (accept, REQ, WAIT); store latency is at least 2 cycles.
REQ-033 Back-to-back: an op presented in the cycle the FSM returns to IDLE is accepted on that edge.

Reset
REQ-034 rst_i=0 at an edge forces:
  - state IDLE and timeout counter 0;
  - every output 0, including dmem_req_o;
  - any outstanding request abandoned mid-operation without writeback.
REQ-035 gnt and rvalid arriving after reset release SHALL be ignored while in IDLE.

Structure
REQ-036 The state encoding, DW default and the 3-bit register index width SHALL live in a shared package used by the pipeline stages.
REQ-037 The timeout counter SHALL be a sub-module lsu_timeout_ctr with clear, enable, limit and expire signals.

Verification
REQ-038 Non-memory op, ex_result_i=0x1234, rd=3 at T -> wb_valid_o=1, wb_val_o=0x1234, wb_rd_idx_o=3 at T+1; stall never high.
REQ-039 Load at addr 0x0040, rd=5, grant after 2 cycles, rvalid 3 cycles later with 0xBEEF:
  - addr held stable throughout REQ;
  - wb_val_o=0xBEEF, wb_rd_idx_o=5;
  - lsu_stall_o high for exactly the REQ and WAIT cycles.
REQ-040 Store at addr 0x0010 with data 0xA5A5 and immediate grant:
  - dmem_we_o=1 and dmem_wdata_o=0xA5A5 during REQ;
  - wb_valid_o pulse with rd=0 on the next cycle.
REQ-041 Load with rvalid withheld -> lsu_err_o single pulse after 15 WAIT cycles, no wb_valid_o, FSM back to IDLE.
REQ-042 Reset asserted during WAIT, followed by a stale rvalid -> all outputs 0, no writeback.
REQ-043 A second load is presented on the edge the first completes -> it is accepted with no bubble.
